// File: rtl/alu_if.sv
// Operand/select/result bundle for the accumulator ALU.
// The producer drives A, B and ALU_Sel, and the ALU returns the registered Acc.
interface alu_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_Sel;
    logic [WIDTH-1:0] Acc;

    modport master (
        output A,
        output B,
        output ALU_Sel,
        input  Acc
    );

    modport slave (
        input  A,
        input  B,
        input  ALU_Sel,
        output Acc
    );
endinterface

// File: rtl/alu.sv
// Unsigned 16-operation ALU. The result is loaded into an accumulator on every rising edge.
// Acc comes straight from the accumulator flops, so nothing combinational reaches the output.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_result;

    always_comb begin
        w_result = ZERO;
        unique case (bus.ALU_Sel)
            4'b0000: w_result = bus.A + bus.B;
            4'b0001: w_result = bus.A - bus.B;
            4'b0010: w_result = bus.A * bus.B;
            // A divisor of zero saturates to all ones instead of being left to the tool.
            4'b0011: w_result = (bus.B == ZERO) ? ALL_ONES : (bus.A / bus.B);
            4'b0100: w_result = bus.A << 1;
            4'b0101: w_result = bus.A >> 1;
            4'b0110: w_result = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
            4'b0111: w_result = {bus.A[0], bus.A[WIDTH-1:1]};
            4'b1000: w_result = bus.A & bus.B;
            4'b1001: w_result = bus.A | bus.B;
            4'b1010: w_result = bus.A ^ bus.B;
            4'b1011: w_result = ~(bus.A | bus.B);
            4'b1100: w_result = ~(bus.A & bus.B);
            4'b1101: w_result = ~(bus.A ^ bus.B);
            4'b1110: w_result = (bus.A > bus.B)  ? ONE : ZERO;
            4'b1111: w_result = (bus.A == bus.B) ? ONE : ZERO;
            default: w_result = ZERO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= ZERO;
        end else begin
            r_acc <= w_result;
        end
    end

    assign bus.Acc = r_acc;
endmodule

// File: tb/tb_alu.sv
// Directed bench for the accumulator ALU: reset, opcode sweep, wrap, divide/compare,
// shift/rotate, mid-run reset and one-cycle latency, using hand-computed results.
module tb_alu;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_if #(.WIDTH(8)) bus ();

    alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; the result is checked 1 unit after the next edge.
    task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                         input logic [7:0] exp, input string tag);
        bus.A       = a;
        bus.B       = b;
        bus.ALU_Sel = sel;
        @(posedge clk);
        #1;
        check(tag, bus.Acc, exp);
    endtask

    logic [7:0] sweep_exp [16];

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        bus.A       = 8'h55;
        bus.B       = 8'hAA;
        bus.ALU_Sel = 4'b0000;
        sweep_exp   = '{8'h02, 8'h00, 8'h01, 8'h01, 8'h02, 8'h00, 8'h02, 8'h80,
                        8'h01, 8'h01, 8'h00, 8'hFE, 8'hFE, 8'hFF, 8'h00, 8'h01};

        // Reset held for two edges with live operands
        @(posedge clk);
        #1;
        check("reset_edge1", bus.Acc, 8'h00);
        @(posedge clk);
        #1;
        check("reset_edge2", bus.Acc, 8'h00);
        rst_n = 1'b1;
        apply(8'h55, 8'hAA, 4'b0000, 8'hFF, "reset_release_add");

        // Opcode sweep with A=B=01
        for (int i = 0; i < 16; i++) begin
            apply(8'h01, 8'h01, 4'(i), sweep_exp[i], $sformatf("sweep_op%0d", i));
        end

        // Wrap and truncation
        apply(8'hFF, 8'h01, 4'b0000, 8'h00, "add_wrap");
        apply(8'h00, 8'h01, 4'b0001, 8'hFF, "sub_wrap");
        apply(8'h10, 8'h10, 4'b0010, 8'h00, "mul_trunc_0");
        apply(8'h0F, 8'h11, 4'b0010, 8'hFF, "mul_trunc_ff");

        // Divide and compare
        apply(8'h07, 8'h02, 4'b0011, 8'h03, "div_7_2");
        apply(8'h07, 8'h00, 4'b0011, 8'hFF, "div_by_zero");
        apply(8'h80, 8'h7F, 4'b1110, 8'h01, "gt_unsigned_true");
        apply(8'h7F, 8'h80, 4'b1110, 8'h00, "gt_unsigned_false");
        apply(8'h5A, 8'h5A, 4'b1110, 8'h00, "gt_equal");
        apply(8'h5A, 8'h5B, 4'b1111, 8'h00, "eq_false");

        // Shift/rotate with A=81; B is varied to show it is ignored
        apply(8'h81, 8'h00, 4'b0100, 8'h02, "shl");
        apply(8'h81, 8'hFF, 4'b0101, 8'h40, "shr");
        apply(8'h81, 8'h3C, 4'b0110, 8'h03, "rol");
        apply(8'h81, 8'hC3, 4'b0111, 8'hC0, "ror");

        // Reset asserted mid-run
        apply(8'h01, 8'h01, 4'b0000, 8'h02, "run_before_reset");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset", bus.Acc, 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_mid_reset", bus.Acc, 8'h02);

        // Latency: an input change between edges must not reach Acc until the next edge
        bus.A = 8'h05;
        @(negedge clk);
        check("latency_hold", bus.Acc, 8'h02);
        @(posedge clk);
        #1;
        check("latency_update", bus.Acc, 8'h06);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
